// File: rtl/fifo_serializer_if.sv
// Bundle between the FIFO read port, the serializer and its downstream bit sink.
interface fifo_serializer_if #(
  parameter int unsigned FIFO_WIDTH = 16,
  parameter int unsigned CNT_WIDTH  = 8
);
  logic                  fifo_empty;
  logic [FIFO_WIDTH-1:0] fifo_data_out;
  logic                  fifo_rd_en;
  logic                  ser_ready;
  logic                  ser_valid;
  logic                  ser_bit;
  logic                  ser_first;
  logic                  busy;
  logic [CNT_WIDTH-1:0]  word_count;

  modport master (
    input  fifo_empty, fifo_data_out, ser_ready,
    output fifo_rd_en, ser_valid, ser_bit, ser_first, busy, word_count
  );

  modport slave (
    output fifo_empty, fifo_data_out, ser_ready,
    input  fifo_rd_en, ser_valid, ser_bit, ser_first, busy, word_count
  );
endinterface

// File: rtl/fifo_serializer.sv
// FIFO drain stage: pops one word at a time and shifts it out MSB-first on a
// one-bit valid/ready stream, counting completed words.
module fifo_serializer #(
  parameter int unsigned FIFO_WIDTH = 16,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  fifo_serializer_if.master bus
);
  localparam int unsigned BW = (FIFO_WIDTH > 1) ? $clog2(FIFO_WIDTH) : 1;
  localparam logic [BW-1:0] BIT_TOP = BW'(FIFO_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RD, LOAD, SHIFT} state_t;

  state_t                state, state_nxt;
  logic [FIFO_WIDTH-1:0] shreg;
  logic [BW-1:0]         bitcnt;
  logic [CNT_WIDTH-1:0]  word_count;
  logic                  rd_en, valid, load_en, shift_en, last_xfer;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    valid     = 1'b0;
    load_en   = 1'b0;
    shift_en  = 1'b0;
    last_xfer = 1'b0;
    case (state)
      IDLE:  if (!bus.fifo_empty) state_nxt = RD;
      RD: begin
        rd_en     = 1'b1;
        state_nxt = LOAD;
      end
      LOAD: begin
        load_en   = 1'b1;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        valid = 1'b1;
        if (bus.ser_ready) begin
          if (bitcnt == '0) begin
            // fifo_empty is only consulted here and in IDLE, so one read at most is in flight
            last_xfer = 1'b1;
            state_nxt = bus.fifo_empty ? IDLE : RD;
          end else begin
            shift_en = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg      <= '0;
      bitcnt     <= '0;
      word_count <= '0;
    end else begin
      if (load_en) begin
        shreg  <= bus.fifo_data_out;
        bitcnt <= BIT_TOP;
      end else if (shift_en) begin
        shreg  <= shreg << 1;
        bitcnt <= bitcnt - 1'b1;
      end
      if (last_xfer) word_count <= word_count + 1'b1;
    end
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.ser_valid  = valid;
  assign bus.ser_bit    = valid & shreg[FIFO_WIDTH-1];
  assign bus.ser_first  = valid & (bitcnt == BIT_TOP);
  assign bus.busy       = (state != IDLE);
  assign bus.word_count = word_count;
endmodule

// File: tb/tb_fifo_serializer.sv
// Scoreboard bench: a queue-based FIFO model feeds the serializer; expected bits
// are queued at write time and popped by an independent negedge monitor.
module tb_fifo_serializer;
  localparam int W  = 16;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_serializer_if #(.FIFO_WIDTH(W), .CNT_WIDTH(CW)) bus ();
  fifo_serializer #(.FIFO_WIDTH(W), .CNT_WIDTH(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0]  fifo_q[$];
  logic [2:0]    exp_q[$];    // {last, first, bit}
  logic [CW-1:0] exp_count = '0;
  int            words_done = 0;
  int            cyc = 0;
  int            rd_cyc[$];
  int            start_cyc[$];
  int            valid_cnt = 0;
  bit            rd_pending = 0;
  bit            garbage = 0;
  int            ready_mode = 0;
  int            bp_i = 0;
  logic          prev_stall = 1'b0, prev_valid = 1'b0, prev_bit = 1'b0, prev_first = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_word(input logic [W-1:0] w);
    fifo_q.push_back(w);
    for (int i = W - 1; i >= 0; i--) exp_q.push_back({(i == 0), (i == W - 1), w[i]});
    bus.fifo_empty = 1'b0;
  endtask

  // FIFO model: read data appears the cycle after rd_en is sampled
  always @(negedge clk) rd_pending = (bus.fifo_rd_en === 1'b1) && !rst;
  always @(posedge clk) begin
    #1;
    if (rd_pending) begin
      if (fifo_q.size() > 0) bus.fifo_data_out = fifo_q.pop_front();
      rd_pending = 0;
    end else if (garbage) begin
      bus.fifo_data_out = W'($urandom);
    end
    bus.fifo_empty = (fifo_q.size() == 0);
  end

  always @(negedge clk) begin
    logic [2:0] e;
    cyc++;
    if (rst) begin
      prev_stall = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (bus.fifo_rd_en) begin
        rd_cyc.push_back(cyc);
        check("rd_while_empty", (fifo_q.size() != 0), 1);
      end
      if (bus.ser_valid) valid_cnt++;
      if (bus.ser_valid && bus.ser_first && !prev_valid) start_cyc.push_back(cyc);
      if (bus.ser_valid || bus.fifo_rd_en) check("busy_active", bus.busy, 1);
      if (prev_stall) begin
        check("hold_valid", bus.ser_valid, 1);
        check("hold_bit", bus.ser_bit, prev_bit);
        check("hold_first", bus.ser_first, prev_first);
      end
      check("word_count", bus.word_count, exp_count);
      if (bus.ser_valid && bus.ser_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_bit: got %0b expected none", bus.ser_bit);
        end else begin
          e = exp_q.pop_front();
          check("ser_bit", bus.ser_bit, e[0]);
          check("ser_first", bus.ser_first, e[1]);
          if (e[2]) begin
            exp_count++;
            words_done++;
          end
        end
      end
      prev_stall = bus.ser_valid && !bus.ser_ready;
      prev_valid = bus.ser_valid;
      prev_bit   = bus.ser_bit;
      prev_first = bus.ser_first;
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       bus.ser_ready = 1'b1;
      1:       bus.ser_ready = 1'($urandom_range(0, 1));
      default: bus.ser_ready = (bp_i >= 12 && bp_i < 17) ? 1'b0 : 1'(bp_i % 2);
    endcase
    bp_i++;
  endtask

  task automatic wait_words(input int target, input int budget, input string name);
    int n = 0;
    while (words_done < target && n < budget) begin
      cycle();
      n++;
    end
    n_cmp++;
    if (words_done < target) begin
      n_bad++;
      $display("FAIL %s_timeout: words %0d expected %0d", name, words_done, target);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_valid"}, bus.ser_valid, 0);
    check({name, "_bit"}, bus.ser_bit, 0);
    check({name, "_first"}, bus.ser_first, 0);
    check({name, "_busy"}, bus.busy, 0);
    check({name, "_rd_en"}, bus.fifo_rd_en, 0);
    check({name, "_count"}, bus.word_count, 0);
  endtask

  initial begin
    int base, vs, n, pushed;
    bus.fifo_empty    = 1'b1;
    bus.fifo_data_out = '0;
    bus.ser_ready     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst = 1'b0;

    // single word, ready held high
    ready_mode = 0;
    rd_cyc.delete();
    start_cyc.delete();
    push_word(16'hA5C3);
    wait_words(1, 100, "single");
    repeat (3) cycle();
    check("single_rd_pulses", rd_cyc.size(), 1);
    check("single_latency",
          (rd_cyc.size() > 0 && start_cyc.size() > 0) ? start_cyc[0] - rd_cyc[0] : -1, 2);
    check("single_busy_idle", bus.busy, 0);
    check("single_count", bus.word_count, 1);

    // asynchronous reset in the middle of a word
    push_word(16'hBEEF);
    n = 0;
    while (!bus.ser_valid && n < 20) begin
      cycle();
      n++;
    end
    check("midword_reached_shift", bus.ser_valid, 1);
    repeat (5) cycle();
    #2;
    rst = 1'b1;
    exp_q.delete();
    exp_count = '0;
    #1;
    check_reset_outputs("async_rst");
    @(posedge clk);
    #3;
    rst = 1'b0;
    vs = valid_cnt;
    repeat (5) cycle();
    check("post_rst_no_valid", valid_cnt - vs, 0);
    check("post_rst_idle", bus.busy, 0);

    // back-to-back words
    rd_cyc.delete();
    base = words_done;
    push_word(16'hFFFF);
    push_word(16'h0001);
    push_word(16'h8000);
    wait_words(base + 3, 200, "b2b");
    repeat (4) cycle();
    check("b2b_rd_pulses", rd_cyc.size(), 3);
    check("b2b_gap1", (rd_cyc.size() >= 2) ? rd_cyc[1] - rd_cyc[0] : -1, 18);
    check("b2b_gap2", (rd_cyc.size() >= 3) ? rd_cyc[2] - rd_cyc[1] : -1, 18);
    check("b2b_count", bus.word_count, 3);
    check("b2b_busy_idle", bus.busy, 0);
    check("b2b_fifo_drained", fifo_q.size(), 0);

    // backpressure: alternating ready plus a 5-cycle low stretch
    ready_mode = 2;
    bp_i = 0;
    base = words_done;
    push_word(16'h1234);
    wait_words(base + 1, 200, "backpressure");
    ready_mode = 0;
    repeat (3) cycle();
    check("bp_count", bus.word_count, 4);

    // empty guard with junk on the data bus
    garbage = 1;
    rd_cyc.delete();
    vs = valid_cnt;
    repeat (50) cycle();
    check("empty_no_rd", rd_cyc.size(), 0);
    check("empty_no_valid", valid_cnt - vs, 0);
    check("empty_count", bus.word_count, 4);
    garbage = 0;

    // clean reset, then 257 random words with random ready
    @(posedge clk);
    #3;
    rst = 1'b1;
    exp_q.delete();
    exp_count = '0;
    @(posedge clk);
    #3;
    rst = 1'b0;
    ready_mode = 1;
    base = words_done;
    pushed = 0;
    n = 0;
    while (words_done < base + 257 && n < 40000) begin
      if (pushed < 257 && fifo_q.size() < 3 && $urandom_range(0, 1) == 1) begin
        push_word(W'($urandom));
        pushed++;
      end
      cycle();
      n++;
    end
    check("wrap_words_done", words_done - base, 257);
    ready_mode = 0;
    repeat (4) cycle();
    check("wrap_count", bus.word_count, 1);
    check("wrap_bits_left", exp_q.size(), 0);
    check("wrap_busy_idle", bus.busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fifo_serializer.md
# fifo_serializer

Read-side drain stage placed directly downstream of the FIFO. It pops one FIFO_WIDTH-bit word at a time whenever the FIFO is not empty. It shifts each word out MSB-first as a one-bit valid/ready stream. It keeps a running count of completed words, so the bench can check drain progress against write activity.

## Interface
Parameters:
- FIFO_WIDTH, 16, word width; must match the FIFO's FIFO_WIDTH.
- CNT_WIDTH, 8, width of the completed-word counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high; one clock only.
- fifo_empty  in  1  FIFO empty flag.
- fifo_data_out  in  FIFO_WIDTH  FIFO read data; valid the cycle after fifo_rd_en is sampled high.
- fifo_rd_en  out  1  read strobe to the FIFO.
- ser_ready  in  1  downstream accepts the current bit.
- ser_valid  out  1  ser_bit is valid.
- ser_bit  out  1  current serial bit, MSB first.
- ser_first  out  1  high while ser_bit is bit FIFO_WIDTH-1 of a word.
- busy  out  1  high in any state other than IDLE.
- word_count  out  CNT_WIDTH  number of words fully shifted out.

## Operation
FSM states: IDLE, RD, LOAD, SHIFT.
- IDLE
  - Outputs: fifo_rd_en=0, ser_valid=0.
  - Transition: if fifo_empty=0, go to RD; else stay.
- RD
  - Outputs: fifo_rd_en=1 for exactly this one cycle (Moore output, registered state, no combinational path from fifo_empty).
  - Transition: always go to LOAD.
- LOAD
  - Action: on the clock edge, shreg <= fifo_data_out and bitcnt <= FIFO_WIDTH-1.
  - Outputs: ser_valid=0.
  - Transition: go to SHIFT.
- SHIFT
  - Outputs: ser_valid=1, ser_bit=shreg[FIFO_WIDTH-1], ser_first=(bitcnt==FIFO_WIDTH-1).
  - On ser_ready=1 with bitcnt!=0: shreg <= shreg<<1, bitcnt <= bitcnt-1.
  - On ser_ready=1 with bitcnt==0: word_count <= word_count+1, then go to RD if fifo_empty=0, else IDLE.
  - On ser_ready=0: shreg, bitcnt and all outputs hold.
- Rules:
  - At most one read is outstanding, so the block never reads an empty FIFO. fifo_rd_en is never high while fifo_empty was high in the preceding IDLE/SHIFT decision cycle.
  - word_count wraps modulo 2^CNT_WIDTH (255 -> 0 at default).
  - bitcnt width is $clog2(FIFO_WIDTH).

## Timing
- Reset values (rst=1, asynchronous, independent of clk): state=IDLE, fifo_rd_en=0, ser_valid=0, ser_bit=0, ser_first=0, busy=0, word_count=0, shreg=0, bitcnt=0.
- Reset mid-word: the partially shifted word is discarded and not counted. Reset in RD: the FIFO read still occurs on the FIFO side, and the word is lost (accepted behaviour).
- Latency: fifo_empty falls in cycle N (sampled at edge N+1) -> RD in cycle N+1 -> LOAD in N+2 -> first ser_valid in N+3.
- Throughput with ser_ready held high: FIFO_WIDTH cycles in SHIFT + 2 cycles (RD, LOAD) per word. That is 18 cycles per 16-bit word back-to-back.
- Handshake: a bit transfers on the rising edge where ser_valid=1 and ser_ready=1. ser_bit and ser_first are stable while ser_valid=1 and ser_ready=0. ser_valid never drops mid-word.
- word_count increments on the same edge that transfers the LSB.
- fifo_empty is sampled only in IDLE and on the LSB-transfer edge. Changes at other times have no effect until then.

## Test plan
- Reset: assert rst mid-SHIFT, asynchronously between edges -> all outputs at reset values immediately; after release, no ser_valid until fifo_empty=0.
- Single word: FIFO holds 16'hA5C3, ser_ready=1 -> one fifo_rd_en pulse; ser_valid 2 cycles later; bit stream 1010_0101_1100_0011; ser_first only on the first bit; word_count 0->1; then IDLE with busy=0.
- Back-to-back: FIFO holds 16'hFFFF, 16'h0001, 16'h8000 -> rd_en pulses exactly 18 cycles apart; serial output matches all three words in order; word_count=3; FIFO empty at end with no extra rd_en.
- Backpressure: 16'h1234 with ser_ready toggling 0/1 each cycle plus a 5-cycle low stretch mid-word -> ser_bit/ser_first stable while ready=0; correct 16-bit sequence; count increments once.
- Empty guard: fifo_empty=1 for 50 cycles, with random fifo_data_out -> fifo_rd_en never asserted, ser_valid=0, word_count unchanged.
- Wrap: drain 257 words with random data and random ser_ready -> word_count reads 1; scoreboard matches every bit against FIFO write order.
